alu_result_deser: RTL and testbench
===================================

ALU_RESULT_DESER -- requirements
Module: alu_result_deser

Interface
REQ-001 The block SHALL have these ports: clk  in  1  single clock, all state on posedge.
REQ-002 rst_n  in  1  asynchronous active-low reset.
REQ-003 sin  in  1  serial result bit from the ALU (its dout).
REQ-004 sin_valid  in  1  qualifies sin (the ALU's dout_valid); sampled each posedge.
REQ-005 res_status  out  8  status byte of the last good frame.
REQ-006 res_data  out  16  result of the last good frame, {word1 data, word2 data}.
REQ-007 res_valid  out  1  result held and available.
REQ-008 res_ready  in  1  consumer accepts the result when res_valid and res_ready are both high at a posedge.
REQ-009 parity_err  out  1  one-cycle pulse: frame dropped on a word parity failure.
REQ-010 frame_err  out  1  one-cycle pulse: frame dropped on a marker error or truncation.
REQ-011 overrun  out  1  one-cycle pulse: good frame dropped because the held result was not yet consumed.
REQ-012 The interface SHALL be one clock; reset is asynchronous and active-low.

Function
REQ-013 A frame SHALL be 30 bits: three 10-bit words, each word sent MSB first as marker, data[7:0] MSB first, then parity.
REQ-014 Word0 SHALL carry status with marker 1; word1 (result[15:8]) and word2 (result[7:0]) SHALL carry marker 0.
REQ-015 Each word SHALL have odd parity over all 10 bits; any failing word SHALL raise parity_err.
REQ-016 FSM states: IDLE, SHIFT, DONE; a 5-bit bit counter SHALL count 0..29.
REQ-017 IDLE->SHIFT on the first posedge with sin_valid=1; that bit SHALL be counted as bit 0.
REQ-018 SHIFT SHALL capture one bit per posedge while sin_valid=1; after bit 29 it SHALL go to DONE.
REQ-019 sin_valid=0 in SHIFT before bit 29 SHALL abort the frame: frame_err pulses, return to IDLE, no result update.
REQ-020 DONE SHALL last one cycle; the check result SHALL appear in that cycle, so latency is 1 clk from the bit-29 sample to res_valid/error pulse.
REQ-021 Priority on DONE: a parity failure SHALL raise parity_err only; else a marker error SHALL raise frame_err; else the frame is good.
REQ-022 A good frame SHALL load res_status/res_data and set res_valid if res_valid=0, or if res_valid=1 and res_ready=1 in the same cycle (simultaneous accept and load: res_valid stays 1 with the new data).
REQ-023 A good frame with res_valid=1 and res_ready=0 SHALL be discarded with an overrun pulse; the held result is unchanged.
REQ-024 res_valid SHALL clear on accept when no new load happens that cycle; res_status/res_data SHALL hold their values after accept.
REQ-025 sin_valid=1 during DONE SHALL be sampled as bit 0 of the next frame (back-to-back frames, no gap needed).
REQ-026 Error frames SHALL never modify res_status, res_data or res_valid.

Reset
REQ-027 rst_n low SHALL force IDLE, counter 0, shift register 0, res_status=0, res_data=0, and res_valid, parity_err, frame_err, overrun all 0.
REQ-028 Reset mid-frame SHALL discard the partial frame silently, with no error pulse after release.

Structure
REQ-029 The shared package alu_pkg SHALL hold WORD_BITS=10, FRAME_WORDS=3, FRAME_BITS=30, the marker constants and the FSM state typedef.
REQ-030 A sub-module alu_word_check (10-bit word -> data[7:0], marker, parity_ok; combinational) SHALL be instantiated three times.

Verification
REQ-031 Good frame 1_00000000_0, 0_00000001_0, 0_00000000_1 with res_ready=1 -> res_valid 1 clk after bit 29, res_status=0x00, res_data=0x0100.
REQ-032 Same frame with word1 parity bit flipped -> parity_err single pulse, res_valid stays 0.
REQ-033 sin_valid dropped after bit 14 -> frame_err pulse next cycle, FSM in IDLE, next good frame decodes correctly.
REQ-034 Two good frames back-to-back (0x0100 then 0x00FF) with res_ready=0 -> first held, overrun pulse on second, res_data stays 0x0100.
REQ-035 res_ready asserted in the DONE cycle of the second frame -> res_valid stays 1, res_data=0x00FF, no overrun.
REQ-036 rst_n pulsed low at bit 20 -> all outputs 0 immediately, no error pulse, following frame decodes correctly.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants and FSM state type for the ALU result deserializer.
// A frame is three 10-bit words: marker, data[7:0] MSB first, odd parity bit.
package alu_pkg;

   localparam int unsigned WORD_BITS   = 10;
   localparam int unsigned FRAME_WORDS = 3;
   localparam int unsigned FRAME_BITS  = WORD_BITS * FRAME_WORDS;

   localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS - 1);

   localparam logic MARKER_STATUS = 1'b1;
   localparam logic MARKER_DATA   = 1'b0;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

endpackage

// File: rtl/alu_word_check.sv
// Splits one received word into marker and data and checks its odd parity
// over all ten bits. Purely combinational.
module alu_word_check
   import alu_pkg::*;
(
   input  logic [WORD_BITS-1:0] word,
   output logic [7:0]           data,
   output logic                 marker,
   output logic                 parity_ok
);

   always_comb begin
      marker    = word[WORD_BITS-1];
      data      = word[WORD_BITS-2:1];
      parity_ok = ^word;
   end

endmodule

// File: rtl/alu_result_deser.sv
// Deserializes 30-bit ALU result frames, validates markers and parity, and
// holds the last good result behind a valid/ready handshake.
module alu_result_deser
   import alu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sin,
   input  logic        sin_valid,
   output logic [7:0]  res_status,
   output logic [15:0] res_data,
   output logic        res_valid,
   input  logic        res_ready,
   output logic        parity_err,
   output logic        frame_err,
   output logic        overrun
);

   state_t                  state;
   logic [4:0]              cnt;
   logic [FRAME_BITS-1:0]   shreg;
   logic [FRAME_BITS-1:0]   shreg_nxt;

   logic [7:0] w0_data, w1_data, w2_data;
   logic       w0_mark, w1_mark, w2_mark;
   logic       w0_par,  w1_par,  w2_par;
   logic       par_ok, mark_ok;

   // Word0 arrives first, so it ends up in the top bits of the shift register.
   alu_word_check u_w0 (.word(shreg[29:20]), .data(w0_data), .marker(w0_mark), .parity_ok(w0_par));
   alu_word_check u_w1 (.word(shreg[19:10]), .data(w1_data), .marker(w1_mark), .parity_ok(w1_par));
   alu_word_check u_w2 (.word(shreg[9:0]),   .data(w2_data), .marker(w2_mark), .parity_ok(w2_par));

   always_comb begin
      shreg_nxt = {shreg[FRAME_BITS-2:0], sin};
      par_ok    = w0_par & w1_par & w2_par;
      mark_ok   = (w0_mark == MARKER_STATUS) && (w1_mark == MARKER_DATA) &&
                  (w2_mark == MARKER_DATA);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         shreg      <= '0;
         res_status <= '0;
         res_data   <= '0;
         res_valid  <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
         if (res_valid && res_ready)
            res_valid <= 1'b0;

         case (state)
            IDLE: begin
               if (sin_valid) begin
                  shreg <= shreg_nxt;
                  cnt   <= 5'd1;
                  state <= SHIFT;
               end
            end

            SHIFT: begin
               if (sin_valid) begin
                  shreg <= shreg_nxt;
                  if (cnt == LAST_BIT) begin
                     cnt   <= '0;
                     state <= DONE;
                  end else begin
                     cnt <= cnt + 5'd1;
                  end
               end else begin
                  frame_err <= 1'b1;
                  cnt       <= '0;
                  state     <= IDLE;
               end
            end

            DONE: begin
               // Checks read the completed frame while a new frame may already
               // be shifting in on this same edge.
               if (!par_ok)
                  parity_err <= 1'b1;
               else if (!mark_ok)
                  frame_err <= 1'b1;
               else if (!res_valid || res_ready) begin
                  res_status <= w0_data;
                  res_data   <= {w1_data, w2_data};
                  res_valid  <= 1'b1;
               end else
                  overrun <= 1'b1;

               if (sin_valid) begin
                  shreg <= shreg_nxt;
                  cnt   <= 5'd1;
                  state <= SHIFT;
               end else begin
                  cnt   <= '0;
                  state <= IDLE;
               end
            end

            default: begin
               cnt   <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_result_deser.sv
// Scoreboard bench for alu_result_deser: stimulus pushes expected events,
// a negedge monitor pops and compares each event the DUT presents.
module tb_alu_result_deser;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        sin = 1'b0;
   logic        sin_valid = 1'b0;
   logic        res_ready = 1'b0;
   logic [7:0]  res_status;
   logic [15:0] res_data;
   logic        res_valid;
   logic        parity_err;
   logic        frame_err;
   logic        overrun;

   int checks = 0;
   int failures = 0;

   localparam int EV_GOOD = 0;
   localparam int EV_PERR = 1;
   localparam int EV_FERR = 2;
   localparam int EV_OVR  = 3;

   typedef struct {
      int          kind;
      logic [7:0]  st;
      logic [15:0] d;
   } exp_t;

   exp_t exp_q[$];

   alu_result_deser dut (
      .clk(clk), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid),
      .res_status(res_status), .res_data(res_data), .res_valid(res_valid),
      .res_ready(res_ready), .parity_err(parity_err), .frame_err(frame_err),
      .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic push(input int kind, input logic [7:0] st, input logic [15:0] d);
      exp_t e;
      e.kind = kind; e.st = st; e.d = d;
      exp_q.push_back(e);
   endtask

   task automatic observe(input int kind, input logic [7:0] st, input logic [15:0] d);
      exp_t e;
      if (exp_q.size() == 0) begin
         checks++; failures++;
         $display("FAIL unexpected_event actual_kind=%0d required=none", kind);
         return;
      end
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      if (kind == EV_GOOD && e.kind == EV_GOOD) begin
         check("res_status", {24'd0, st}, {24'd0, e.st});
         check("res_data", {16'd0, d}, {16'd0, e.d});
      end
   endtask

   // A load is a visible res_valid with either no prior valid or an accept
   // on the edge just passed (simultaneous accept-and-load).
   logic pv = 1'b0, pr = 1'b0;
   always @(negedge clk) begin
      if (!rst_n) begin
         pv = 1'b0; pr = 1'b0;
      end else begin
         if (parity_err) observe(EV_PERR, 8'h0, 16'h0);
         if (frame_err)  observe(EV_FERR, 8'h0, 16'h0);
         if (overrun)    observe(EV_OVR, 8'h0, 16'h0);
         if (res_valid && (!pv || pr)) observe(EV_GOOD, res_status, res_data);
         pv = res_valid; pr = res_ready;
      end
   end

   function automatic logic [9:0] mk_word(input logic m, input logic [7:0] d);
      return {m, d, ~^{m, d}};
   endfunction

   function automatic logic [29:0] mk_frame(input logic [7:0] st, input logic [15:0] d);
      return {mk_word(1'b1, st), mk_word(1'b0, d[15:8]), mk_word(1'b0, d[7:0])};
   endfunction

   task automatic send_bits(input logic [29:0] f, input int n);
      for (int i = 0; i < n; i++) begin
         sin_valid = 1'b1;
         sin = f[29 - i];
         @(posedge clk); #1;
      end
   endtask

   task automatic idle(input int n);
      sin_valid = 1'b0;
      sin = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_status"}, {24'd0, res_status}, 32'd0);
      check({tag, "_data"}, {16'd0, res_data}, 32'd0);
      check({tag, "_valid"}, {31'd0, res_valid}, 32'd0);
      check({tag, "_perr"}, {31'd0, parity_err}, 32'd0);
      check({tag, "_ferr"}, {31'd0, frame_err}, 32'd0);
      check({tag, "_ovr"}, {31'd0, overrun}, 32'd0);
   endtask

   logic [29:0] f;

   initial begin
      #2 rst_n = 1'b0;
      #3 check_all_zero("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(2);

      // Good frame: status 0x00, data 0x0100, consumer always ready
      res_ready = 1'b1;
      f = 30'b1000000000_0000000010_0000000001;
      check("hand_vector", {2'b0, f}, {2'b0, mk_frame(8'h00, 16'h0100)});
      push(EV_GOOD, 8'h00, 16'h0100);
      send_bits(f, 30);
      idle(4);

      // Same frame with word1 parity bit flipped
      f[10] = ~f[10];
      push(EV_PERR, 8'h0, 16'h0);
      send_bits(f, 30);
      idle(4);

      // Truncation after bit 14, then a good frame
      push(EV_FERR, 8'h0, 16'h0);
      send_bits(mk_frame(8'h11, 16'h2233), 15);
      idle(3);
      push(EV_GOOD, 8'hA5, 16'h3C5A);
      send_bits(mk_frame(8'hA5, 16'h3C5A), 30);
      idle(4);

      // Marker error on word0 (parity still valid)
      f = {mk_word(1'b0, 8'h12), mk_word(1'b0, 8'h34), mk_word(1'b0, 8'h56)};
      push(EV_FERR, 8'h0, 16'h0);
      send_bits(f, 30);
      idle(3);

      // Marker error on word2 plus parity error: parity wins
      f = {mk_word(1'b1, 8'h12), mk_word(1'b0, 8'h34), mk_word(1'b1, 8'h56)};
      f[0] = ~f[0];
      push(EV_PERR, 8'h0, 16'h0);
      send_bits(f, 30);
      idle(3);

      // Back-to-back frames with consumer stalled: second overruns
      res_ready = 1'b0;
      push(EV_GOOD, 8'h00, 16'h0100);
      push(EV_OVR, 8'h0, 16'h0);
      send_bits(mk_frame(8'h00, 16'h0100), 30);
      send_bits(mk_frame(8'h00, 16'h00FF), 30);
      idle(3);
      check("held_valid", {31'd0, res_valid}, 32'd1);
      check("held_data", {16'd0, res_data}, 32'h0100);

      // Accept in the DONE cycle of a new frame: load replaces held result
      push(EV_GOOD, 8'h00, 16'h00FF);
      send_bits(mk_frame(8'h00, 16'h00FF), 30);
      res_ready = 1'b1;
      sin_valid = 1'b0;
      @(posedge clk); #1;
      res_ready = 1'b0;
      idle(2);
      check("swap_valid", {31'd0, res_valid}, 32'd1);
      check("swap_data", {16'd0, res_data}, 32'h00FF);
      res_ready = 1'b1;
      idle(1);
      res_ready = 1'b0;
      check("accept_clears_valid", {31'd0, res_valid}, 32'd0);
      check("accept_holds_data", {16'd0, res_data}, 32'h00FF);
      idle(2);

      // Reset at bit 20: outputs drop immediately, no error afterwards
      send_bits(mk_frame(8'h77, 16'h8899), 20);
      rst_n = 1'b0;
      #1 check_all_zero("midreset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(5);
      res_ready = 1'b1;
      push(EV_GOOD, 8'h5A, 16'hBEEF);
      send_bits(mk_frame(8'h5A, 16'hBEEF), 30);
      idle(5);

      check("pending_expectations", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
